// File: rtl/redraw_scheduler_pkg.sv
// Shared constants and types for the redraw scheduler slice: move codes,
// FSM state encoding and counter widths.
package redraw_scheduler_pkg;

  localparam int unsigned CODE_W    = 4;
  localparam int unsigned NUM_MOVES = 12;
  localparam int unsigned LVL_W     = 3;
  localparam int unsigned CNT_W     = 15;
  localparam int unsigned COUNT_W   = 16;

  // face*2 + dir, dir 0 = clockwise, 1 = counter-clockwise
  localparam logic [CODE_W-1:0] MV_U_CW  = 4'd0;
  localparam logic [CODE_W-1:0] MV_U_CCW = 4'd1;
  localparam logic [CODE_W-1:0] MV_D_CW  = 4'd2;
  localparam logic [CODE_W-1:0] MV_D_CCW = 4'd3;
  localparam logic [CODE_W-1:0] MV_L_CW  = 4'd4;
  localparam logic [CODE_W-1:0] MV_L_CCW = 4'd5;
  localparam logic [CODE_W-1:0] MV_R_CW  = 4'd6;
  localparam logic [CODE_W-1:0] MV_R_CCW = 4'd7;
  localparam logic [CODE_W-1:0] MV_F_CW  = 4'd8;
  localparam logic [CODE_W-1:0] MV_F_CCW = 4'd9;
  localparam logic [CODE_W-1:0] MV_B_CW  = 4'd10;
  localparam logic [CODE_W-1:0] MV_B_CCW = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_KICK,
    ST_WAIT_START,
    ST_WAIT_DONE
  } sched_state_e;

  function automatic logic is_legal(input logic [CODE_W-1:0] code);
    return code < CODE_W'(NUM_MOVES);
  endfunction

endpackage

// File: rtl/redraw_scheduler_if.sv
// Handshake bundle between keyboard decode / drawer (master side) and the
// redraw scheduler (slave side).
interface redraw_scheduler_if;
  import redraw_scheduler_pkg::*;

  logic               move_valid;
  logic [CODE_W-1:0]  move_code;
  logic               move_ready;
  logic               refresh;
  logic               drawer_busy;
  logic               apply_valid;
  logic [CODE_W-1:0]  apply_code;
  logic               redraw;
  logic               sched_busy;
  logic [LVL_W-1:0]   fifo_level;
  logic [COUNT_W-1:0] move_count;
  logic               timeout_err;

  modport master (
    output move_valid, move_code, refresh, drawer_busy,
    input  move_ready, apply_valid, apply_code, redraw, sched_busy,
           fifo_level, move_count, timeout_err
  );

  modport slave (
    input  move_valid, move_code, refresh, drawer_busy,
    output move_ready, apply_valid, apply_code, redraw, sched_busy,
           fifo_level, move_count, timeout_err
  );
endinterface

// File: rtl/redraw_scheduler_move_fifo.sv
// Small synchronous FIFO holding queued move codes; head is the oldest entry.
module move_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end
endmodule

// File: rtl/redraw_scheduler.sv
// Redraw scheduler: queues legal move codes, applies one at a time to the
// cube logic, then kicks a full redraw and waits for the drawer to finish so
// the cube state never changes mid-draw. Stand-alone refreshes coalesce.
module redraw_scheduler
  import redraw_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYC    = 2,
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned DRAW_TIMEOUT  = 32767
) (
  input  logic               clk,
  input  logic               reset,
  redraw_scheduler_if.slave  bus
);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAW_LAST   = CNT_W'(DRAW_TIMEOUT - 1);

  sched_state_e       state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               apply_valid_d, redraw_d, timeout_d, pop, push;
  logic [CODE_W-1:0]  head;
  logic [LVL_W-1:0]   level;
  logic               full, empty;
  logic               refresh_pend;
  logic               apply_valid_q, redraw_q, sched_busy_q, timeout_err_q;
  logic [CODE_W-1:0]  apply_code_q;
  logic [COUNT_W-1:0] move_count_q;

  // A full queue refuses pushes even when the FSM pops in the same cycle.
  assign push = bus.move_valid & ~full & is_legal(bus.move_code);

  move_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_move_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (bus.move_code),
    .pop   (pop),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Next-state, per-state timer and pulse requests; pulses are registered
  // on the edge that leaves APPLY / KICK.
  always_comb begin
    state_d       = state;
    cnt_d         = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    apply_valid_d = 1'b0;
    redraw_d      = 1'b0;
    timeout_d     = 1'b0;
    pop           = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty)                            state_d = ST_APPLY;
        else if (refresh_pend && !bus.drawer_busy) state_d = ST_KICK;
      end
      ST_APPLY: begin
        apply_valid_d = 1'b1;
        pop           = 1'b1;
        state_d       = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt >= SETTLE_LAST && !bus.drawer_busy) state_d = ST_KICK;
      end
      ST_KICK: begin
        redraw_d = 1'b1;
        state_d  = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (bus.drawer_busy) state_d = ST_WAIT_DONE;
        else if (cnt >= START_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.drawer_busy) state_d = ST_IDLE;
        else if (cnt >= DRAW_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state) cnt_d = '0;
  end

  // State, timer, refresh coalescing and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      refresh_pend  <= 1'b0;
      apply_valid_q <= 1'b0;
      apply_code_q  <= '0;
      redraw_q      <= 1'b0;
      sched_busy_q  <= 1'b0;
      move_count_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      refresh_pend  <= bus.refresh | (refresh_pend & ~redraw_d);
      apply_valid_q <= apply_valid_d;
      if (apply_valid_d) apply_code_q <= head;
      redraw_q      <= redraw_d;
      sched_busy_q  <= (state_d != ST_IDLE);
      if (pop) move_count_q <= move_count_q + COUNT_W'(1);
      timeout_err_q <= timeout_err_q | timeout_d;
    end
  end

  assign bus.move_ready  = ~full;
  assign bus.fifo_level  = level;
  assign bus.apply_valid = apply_valid_q;
  assign bus.apply_code  = apply_code_q;
  assign bus.redraw      = redraw_q;
  assign bus.sched_busy  = sched_busy_q;
  assign bus.move_count  = move_count_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_redraw_scheduler.sv
// Bench for redraw_scheduler: a queue-level scoreboard checked every cycle,
// a simple drawer model, and directed scenarios with literal expectations.
module tb_redraw_scheduler;
  import redraw_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  redraw_scheduler_if bus();

  redraw_scheduler #(
    .FIFO_DEPTH    (4),
    .SETTLE_CYC    (2),
    .START_TIMEOUT (16),
    .DRAW_TIMEOUT  (32767)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int n_apply = 0;
  int n_redraw = 0;
  logic [3:0] applied[$];
  bit drawer_en = 1'b1;
  int draw_len = 100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_move(input logic [3:0] code);
    bus.move_valid = 1'b1;
    bus.move_code  = code;
    step();
    bus.move_valid = 1'b0;
  endtask

  task automatic pulse_refresh();
    bus.refresh = 1'b1;
    step();
    bus.refresh = 1'b0;
  endtask

  task automatic wait_busy(input int limit, input string name);
    int n = 0;
    while (!bus.drawer_busy && n < limit) begin
      step();
      n++;
    end
    check(name, 32'(bus.drawer_busy), 32'd1);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int stable = 0;
    int n = 0;
    while (stable < 3 && n < limit) begin
      step();
      n++;
      if (!bus.sched_busy && bus.fifo_level == 0 && !bus.drawer_busy) stable++;
      else stable = 0;
    end
    check(name, 32'(stable >= 3), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_apply_valid"}, 32'(bus.apply_valid), 32'd0);
    check({tag, "_apply_code"},  32'(bus.apply_code),  32'd0);
    check({tag, "_redraw"},      32'(bus.redraw),      32'd0);
    check({tag, "_sched_busy"},  32'(bus.sched_busy),  32'd0);
    check({tag, "_fifo_level"},  32'(bus.fifo_level),  32'd0);
    check({tag, "_move_count"},  32'(bus.move_count),  32'd0);
    check({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
  endtask

  // Drawer: busy rises one cycle after it sees redraw, stays high draw_len cycles.
  initial begin
    bus.drawer_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.redraw && drawer_en) begin
        @(posedge clk);
        #1 bus.drawer_busy = 1'b1;
        repeat (draw_len) @(posedge clk);
        #1 bus.drawer_busy = 1'b0;
      end
    end
  end

  // Scoreboard: inputs snapshotted at one negedge are the ones the following
  // posedge sampled; at the next negedge that edge's effect is checked.
  initial begin
    logic [3:0] mq[$];
    int         exp_count = 0;
    logic [3:0] exp_code  = '0;
    bit         s_reset = 1'b1, s_valid = 1'b0;
    logic [3:0] s_code = '0;
    bit         prev_redraw = 1'b0, prev_apply = 1'b0;
    forever begin
      @(negedge clk);
      if (s_reset) begin
        mq.delete();
        exp_count = 0;
        exp_code  = '0;
        check_all_zero("reset_state");
      end else begin
        if (s_valid && mq.size() < 4 && int'(s_code) < 12) mq.push_back(s_code);
        if (bus.apply_valid) begin
          n_apply++;
          applied.push_back(bus.apply_code);
          check("apply_expected", 32'(mq.size() > 0), 32'd1);
          if (mq.size() > 0) begin
            exp_code  = mq.pop_front();
            exp_count = (exp_count + 1) % 65536;
          end
          check("apply_not_back_to_back", 32'(prev_apply), 32'd0);
        end
        check("apply_code", 32'(bus.apply_code), 32'(exp_code));
        if (bus.redraw) begin
          n_redraw++;
          check("redraw_single_cycle", 32'(prev_redraw), 32'd0);
        end
        check("fifo_level", 32'(bus.fifo_level), 32'(mq.size()));
        check("move_ready", 32'(bus.move_ready), 32'(mq.size() < 4));
        check("move_count", 32'(bus.move_count), 32'(exp_count));
      end
      prev_redraw = bus.redraw;
      prev_apply  = bus.apply_valid;
      s_reset = reset;
      s_valid = bus.move_valid;
      s_code  = bus.move_code;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nr, base, n;
    bus.move_valid = 1'b0;
    bus.move_code  = '0;
    bus.refresh    = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("t0");
    reset = 1'b0;
    step();

    // 1: single move, exact latency of apply and redraw
    na = n_apply; nr = n_redraw;
    push_move(MV_L_CCW);
    step();
    check("t1_apply_t1", 32'(bus.apply_valid), 32'd0);
    step();
    check("t1_apply_t2", 32'(bus.apply_valid), 32'd1);
    check("t1_code", 32'(bus.apply_code), 32'd5);
    step();
    check("t1_apply_t3", 32'(bus.apply_valid), 32'd0);
    step();
    check("t1_redraw_t4", 32'(bus.redraw), 32'd0);
    step();
    check("t1_redraw_t5", 32'(bus.redraw), 32'd1);
    wait_idle(400, "t1_idle");
    check("t1_n_apply", 32'(n_apply - na), 32'd1);
    check("t1_n_redraw", 32'(n_redraw - nr), 32'd1);
    check("t1_move_count", 32'(bus.move_count), 32'd1);
    check("t1_sched_busy", 32'(bus.sched_busy), 32'd0);

    // 2: fill queue while drawer busy; fifth push rejected
    pulse_refresh();
    wait_busy(20, "t2_busy");
    base = applied.size();
    push_move(MV_U_CCW);
    push_move(MV_D_CW);
    push_move(MV_D_CCW);
    push_move(MV_L_CW);
    check("t2_level_full", 32'(bus.fifo_level), 32'd4);
    check("t2_ready_low", 32'(bus.move_ready), 32'd0);
    push_move(MV_R_CW);
    check("t2_level_after_reject", 32'(bus.fifo_level), 32'd4);
    wait_idle(2000, "t2_idle");
    check("t2_n_apply", 32'(applied.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < applied.size())
        check("t2_order", 32'(applied[base + i]), 32'(i + 1));
    check("t2_move_count", 32'(bus.move_count), 32'd5);
    check("t2_level_empty", 32'(bus.fifo_level), 32'd0);

    // 3: illegal code dropped
    na = n_apply; nr = n_redraw;
    push_move(4'd13);
    repeat (10) step();
    check("t3_level", 32'(bus.fifo_level), 32'd0);
    check("t3_no_apply", 32'(n_apply - na), 32'd0);
    check("t3_no_redraw", 32'(n_redraw - nr), 32'd0);

    // 4: three refreshes during one draw coalesce into one extra redraw
    nr = n_redraw;
    pulse_refresh();
    wait_busy(20, "t4_busy");
    repeat (10) step();
    pulse_refresh();
    repeat (20) step();
    pulse_refresh();
    step();
    pulse_refresh();
    wait_idle(1000, "t4_idle");
    check("t4_n_redraw", 32'(n_redraw - nr), 32'd2);

    // 5: drawer never starts -> timeout after 16 cycles, next move still runs
    drawer_en = 1'b0;
    push_move(MV_R_CCW);
    n = 0;
    while (!bus.redraw && n < 20) begin
      step();
      n++;
    end
    check("t5_redraw_seen", 32'(bus.redraw), 32'd1);
    repeat (15) step();
    check("t5_timeout_early", 32'(bus.timeout_err), 32'd0);
    step();
    check("t5_timeout_set", 32'(bus.timeout_err), 32'd1);
    check("t5_fsm_idle", 32'(bus.sched_busy), 32'd0);
    drawer_en = 1'b1;
    push_move(MV_F_CW);
    wait_idle(400, "t5_idle");
    check("t5_last_code", 32'(applied[$]), 32'd8);
    check("t5_timeout_sticky", 32'(bus.timeout_err), 32'd1);
    check("t5_move_count", 32'(bus.move_count), 32'd7);

    // 6: reset during WAIT_DONE with two queued moves
    pulse_refresh();
    wait_busy(20, "t6_busy");
    push_move(MV_F_CCW);
    push_move(MV_B_CW);
    check("t6_level_before", 32'(bus.fifo_level), 32'd2);
    check("t6_busy_before", 32'(bus.sched_busy), 32'd1);
    reset = 1'b1;
    step();
    check_all_zero("t6");
    reset = 1'b0;
    na = n_apply; nr = n_redraw;
    repeat (300) step();
    check("t6_no_apply", 32'(n_apply - na), 32'd0);
    check("t6_no_redraw", 32'(n_redraw - nr), 32'd0);
    check("t6_level", 32'(bus.fifo_level), 32'd0);
    check("t6_idle", 32'(bus.sched_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
